// File: rtl/hdmi_line_fetch_sched_if.sv
// rtl/hdmi_line_fetch_sched_if.sv - burst request/completion bus between line fetch scheduler and read master
//
// Purpose: groups the read-master handshake so the scheduler and its peer are
// connected with a single port.
// Signals:
//   rd_req   scheduler -> master  burst request, held until rd_ack
//   rd_addr  scheduler -> master  burst start byte address
//   rd_len   scheduler -> master  burst length in bytes (never 0)
//   rd_ack   master -> scheduler  request accepted
//   rd_done  master -> scheduler  1-cycle pulse, burst data is in the FIFO
interface hdmi_line_fetch_sched_if;
   logic        rd_req;
   logic [31:0] rd_addr;
   logic [11:0] rd_len;
   logic        rd_ack;
   logic        rd_done;

   modport master (
      output rd_req,
      output rd_addr,
      output rd_len,
      input  rd_ack,
      input  rd_done
   );

   modport slave (
      input  rd_req,
      input  rd_addr,
      input  rd_len,
      output rd_ack,
      output rd_done
   );
endinterface

// File: rtl/hdmi_line_fetch_sched.sv
// rtl/hdmi_line_fetch_sched.sv - schedules DDR read bursts that keep the HDMI line FIFO filled for a frame
//
// Purpose: walks the frame buffer line by line (base, stride, active bytes per
// line) and issues one burst at a time to the read master, waiting for enough
// FIFO space before each burst.
// Ports:
//   Bus2IP_Clk       clock, rising edge
//   Bus2IP_Resetn    asynchronous active-low reset
//   enable           software run request
//   frame_base_addr  byte address of first pixel of the frame
//   line_stride      byte distance between line starts
//   bytes_per_line   active bytes per line (multiple of 4)
//   lines_per_frame  active lines per frame
//   vsync            1-cycle frame-start pulse
//   fifo_level       words currently held in the line FIFO
//   rd_bus           burst request/ack/done bus (master side)
//   busy             frame fetch in progress
//   frame_done       1-cycle pulse when the last burst of a frame completes
module hdmi_line_fetch_sched #(
   parameter int BURST_BYTES = 256,
   parameter int FIFO_WORDS  = 128,
   parameter int LVL_W       = 8
) (
   input  logic                    Bus2IP_Clk,
   input  logic                    Bus2IP_Resetn,
   input  logic                    enable,
   input  logic [31:0]             frame_base_addr,
   input  logic [31:0]             line_stride,
   input  logic [31:0]             bytes_per_line,
   input  logic [15:0]             lines_per_frame,
   input  logic                    vsync,
   input  logic [LVL_W-1:0]        fifo_level,
   hdmi_line_fetch_sched_if.master rd_bus,
   output logic                    busy,
   output logic                    frame_done
);

   localparam logic [31:0] BURST_B     = 32'(BURST_BYTES);
   localparam logic [31:0] BURST_WORDS = 32'(BURST_BYTES / 4);
   localparam logic [31:0] FIFO_W32    = 32'(FIFO_WORDS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_FRAME,
      S_CHECK,
      S_REQ,
      S_XFER
   } state_t;

   state_t      state_q, state_d;

   // Configuration in use for the current frame.
   logic [31:0] stride_q, stride_d;
   logic [31:0] bpl_q, bpl_d;
   logic [15:0] lines_q, lines_d;

   // Position within the frame.
   logic [31:0] line_addr_q, line_addr_d;
   logic [31:0] col_q, col_d;
   logic [15:0] line_q, line_d;

   // Configuration captured by a vsync that arrived while a burst was in
   // flight; applied once that burst's rd_done arrives.
   logic [31:0] pend_base_q, pend_base_d;
   logic [31:0] pend_stride_q, pend_stride_d;
   logic [31:0] pend_bpl_q, pend_bpl_d;
   logic [15:0] pend_lines_q, pend_lines_d;
   logic        resync_q, resync_d;

   // enable dropped while a burst was in flight: finish it, then go idle.
   logic        stop_q, stop_d;

   logic        rd_req_q, rd_req_d;
   logic [31:0] rd_addr_q, rd_addr_d;
   logic [11:0] rd_len_q, rd_len_d;
   logic        frame_done_q, frame_done_d;

   // Combinational helpers.
   logic        vsync_ok;
   logic        space_ok;
   logic        in_flight;
   logic [31:0] remain;
   logic [31:0] burst_len;
   logic [31:0] col_next;
   logic [31:0] ld_base;
   logic [31:0] ld_stride;
   logic [31:0] ld_bpl;
   logic [15:0] ld_lines;

   // A frame with zero lines or zero bytes per line cannot be fetched, so a
   // vsync carrying such a configuration is treated as if it never came.
   assign vsync_ok  = vsync && (bytes_per_line != 32'd0) && (lines_per_frame != 16'd0);

   // Free space test done without subtraction so a level above the FIFO depth
   // simply reads as "no space" instead of wrapping.
   assign space_ok  = (32'(fifo_level) + BURST_WORDS) <= FIFO_W32;

   assign in_flight = (state_q == S_REQ) || (state_q == S_XFER);

   // Bursts are clipped at the end of the line so no burst spans two lines.
   assign remain    = bpl_q - col_q;
   assign burst_len = (remain > BURST_B) ? BURST_B : remain;
   assign col_next  = col_q + 32'(rd_len_q);

   // Configuration to start a frame from: a vsync in this very cycle is the
   // latest one and wins over anything captured earlier.
   assign ld_base   = vsync_ok ? frame_base_addr : pend_base_q;
   assign ld_stride = vsync_ok ? line_stride     : pend_stride_q;
   assign ld_bpl    = vsync_ok ? bytes_per_line  : pend_bpl_q;
   assign ld_lines  = vsync_ok ? lines_per_frame : pend_lines_q;

   always_comb begin
      state_d       = state_q;
      stride_d      = stride_q;
      bpl_d         = bpl_q;
      lines_d       = lines_q;
      line_addr_d   = line_addr_q;
      col_d         = col_q;
      line_d        = line_q;
      pend_base_d   = pend_base_q;
      pend_stride_d = pend_stride_q;
      pend_bpl_d    = pend_bpl_q;
      pend_lines_d  = pend_lines_q;
      resync_d      = resync_q;
      stop_d        = stop_q;
      rd_req_d      = rd_req_q;
      rd_addr_d     = rd_addr_q;
      rd_len_d      = rd_len_q;
      frame_done_d  = 1'b0;

      // While a burst is outstanding, remember restart/stop requests; the
      // bus transaction itself is never cut short.
      if (in_flight) begin
         if (vsync_ok) begin
            pend_base_d   = frame_base_addr;
            pend_stride_d = line_stride;
            pend_bpl_d    = bytes_per_line;
            pend_lines_d  = lines_per_frame;
            resync_d      = 1'b1;
         end
         if (!enable) begin
            stop_d = 1'b1;
         end
      end

      unique case (state_q)
         S_IDLE: begin
            if (enable) begin
               state_d = S_WAIT_FRAME;
            end
         end

         S_WAIT_FRAME: begin
            if (!enable) begin
               state_d = S_IDLE;
            end else if (vsync_ok) begin
               stride_d    = ld_stride;
               bpl_d       = ld_bpl;
               lines_d     = ld_lines;
               line_addr_d = ld_base;
               col_d       = 32'd0;
               line_d      = 16'd0;
               state_d     = S_CHECK;
            end
         end

         S_CHECK: begin
            if (!enable) begin
               state_d = S_IDLE;
            end else if (vsync_ok) begin
               // Nothing is outstanding here, so a resync restarts at once.
               stride_d    = ld_stride;
               bpl_d       = ld_bpl;
               lines_d     = ld_lines;
               line_addr_d = ld_base;
               col_d       = 32'd0;
               line_d      = 16'd0;
            end else if (space_ok) begin
               rd_req_d  = 1'b1;
               rd_addr_d = line_addr_q + col_q;
               rd_len_d  = burst_len[11:0];
               state_d   = S_REQ;
            end
         end

         S_REQ: begin
            // Address and length registers are untouched here, so they stay
            // stable for as long as the master keeps us waiting.
            if (rd_bus.rd_ack) begin
               rd_req_d = 1'b0;
               state_d  = S_XFER;
            end
         end

         S_XFER: begin
            if (rd_bus.rd_done) begin
               resync_d = 1'b0;
               stop_d   = 1'b0;
               if (stop_q || !enable) begin
                  state_d = S_IDLE;
               end else if (resync_q || vsync_ok) begin
                  stride_d    = ld_stride;
                  bpl_d       = ld_bpl;
                  lines_d     = ld_lines;
                  line_addr_d = ld_base;
                  col_d       = 32'd0;
                  line_d      = 16'd0;
                  state_d     = S_CHECK;
               end else if (col_next == bpl_q) begin
                  col_d       = 32'd0;
                  line_addr_d = line_addr_q + stride_q;
                  line_d      = line_q + 16'd1;
                  if ((line_q + 16'd1) == lines_q) begin
                     frame_done_d = 1'b1;
                     state_d      = S_WAIT_FRAME;
                  end else begin
                     state_d = S_CHECK;
                  end
               end else begin
                  col_d   = col_next;
                  state_d = S_CHECK;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
      if (!Bus2IP_Resetn) begin
         state_q       <= S_IDLE;
         stride_q      <= 32'd0;
         bpl_q         <= 32'd0;
         lines_q       <= 16'd0;
         line_addr_q   <= 32'd0;
         col_q         <= 32'd0;
         line_q        <= 16'd0;
         pend_base_q   <= 32'd0;
         pend_stride_q <= 32'd0;
         pend_bpl_q    <= 32'd0;
         pend_lines_q  <= 16'd0;
         resync_q      <= 1'b0;
         stop_q        <= 1'b0;
         rd_req_q      <= 1'b0;
         rd_addr_q     <= 32'd0;
         rd_len_q      <= 12'd0;
         frame_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         stride_q      <= stride_d;
         bpl_q         <= bpl_d;
         lines_q       <= lines_d;
         line_addr_q   <= line_addr_d;
         col_q         <= col_d;
         line_q        <= line_d;
         pend_base_q   <= pend_base_d;
         pend_stride_q <= pend_stride_d;
         pend_bpl_q    <= pend_bpl_d;
         pend_lines_q  <= pend_lines_d;
         resync_q      <= resync_d;
         stop_q        <= stop_d;
         rd_req_q      <= rd_req_d;
         rd_addr_q     <= rd_addr_d;
         rd_len_q      <= rd_len_d;
         frame_done_q  <= frame_done_d;
      end
   end

   assign rd_bus.rd_req  = rd_req_q;
   assign rd_bus.rd_addr = rd_addr_q;
   assign rd_bus.rd_len  = rd_len_q;

   assign busy       = (state_q == S_CHECK) || in_flight;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hdmi_line_fetch_sched.sv
// tb/tb_hdmi_line_fetch_sched.sv - directed self-checking bench for hdmi_line_fetch_sched
module tb_hdmi_line_fetch_sched;

   logic        clk;
   logic        resetn;
   logic        enable;
   logic [31:0] frame_base_addr;
   logic [31:0] line_stride;
   logic [31:0] bytes_per_line;
   logic [15:0] lines_per_frame;
   logic        vsync;
   logic [7:0]  fifo_level;
   logic        busy;
   logic        frame_done;

   int errors = 0;
   int checks = 0;

   hdmi_line_fetch_sched_if bus ();

   hdmi_line_fetch_sched #(
      .BURST_BYTES (256),
      .FIFO_WORDS  (128),
      .LVL_W       (8)
   ) dut (
      .Bus2IP_Clk      (clk),
      .Bus2IP_Resetn   (resetn),
      .enable          (enable),
      .frame_base_addr (frame_base_addr),
      .line_stride     (line_stride),
      .bytes_per_line  (bytes_per_line),
      .lines_per_frame (lines_per_frame),
      .vsync           (vsync),
      .fifo_level      (fifo_level),
      .rd_bus          (bus),
      .busy            (busy),
      .frame_done      (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [31:0] addr;      // expected rd_addr
      logic [11:0] len;       // expected rd_len
      int          ack_dly;   // cycles before rd_ack
      int          done_dly;  // cycles before rd_done
      bit          last;      // expect frame_done after this burst
   } burst_vec_t;

   burst_vec_t t1 [6];
   burst_vec_t t_wrap [2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_vsync();
      vsync = 1'b1;
      step();
      vsync = 1'b0;
   endtask

   // Wait (bounded) for a request, check it, hold off the ack for ack_dly
   // cycles while checking stability, then ack and check rd_req drops.
   task automatic wait_req(input logic [31:0] exp_addr, input logic [11:0] exp_len,
                           input int ack_dly, input bit drop_en);
      int t = 0;
      while (bus.rd_req !== 1'b1 && t < 50) begin
         step();
         t++;
      end
      chk("req_seen", {31'd0, bus.rd_req}, 32'd1);
      if (bus.rd_req === 1'b1) begin
         chk("rd_addr", bus.rd_addr, exp_addr);
         chk("rd_len", {20'd0, bus.rd_len}, {20'd0, exp_len});
         if (drop_en) enable = 1'b0;
         for (int i = 0; i < ack_dly; i++) begin
            step();
            chk("hold_req", {31'd0, bus.rd_req}, 32'd1);
            chk("hold_addr", bus.rd_addr, exp_addr);
            chk("hold_len", {20'd0, bus.rd_len}, {20'd0, exp_len});
         end
         bus.rd_ack = 1'b1;
         step();
         bus.rd_ack = 1'b0;
         chk("req_drop", {31'd0, bus.rd_req}, 32'd0);
      end
   endtask

   task automatic finish_done(input int done_dly, input bit exp_fd, input bit exp_busy);
      step(done_dly);
      bus.rd_done = 1'b1;
      step();
      bus.rd_done = 1'b0;
      chk("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
      chk("busy_after_done", {31'd0, busy}, {31'd0, exp_busy});
      if (exp_fd) begin
         step();
         chk("frame_done_pulse", {31'd0, frame_done}, 32'd0);
      end
   endtask

   initial begin
      t1[0] = '{32'h1000_0000, 12'd256, 3, 3, 1'b0};
      t1[1] = '{32'h1000_0100, 12'd256, 3, 3, 1'b0};
      t1[2] = '{32'h1000_0200, 12'd128, 3, 3, 1'b0};
      t1[3] = '{32'h1000_1000, 12'd256, 3, 3, 1'b0};
      t1[4] = '{32'h1000_1100, 12'd256, 3, 3, 1'b0};
      t1[5] = '{32'h1000_1200, 12'd128, 3, 3, 1'b1};
      t_wrap[0] = '{32'hFFFF_FF00, 12'd4, 0, 1, 1'b0};
      t_wrap[1] = '{32'h0000_0100, 12'd4, 1, 0, 1'b1};

      resetn          = 1'b0;
      enable          = 1'b0;
      frame_base_addr = 32'h1000_0000;
      line_stride     = 32'd4096;
      bytes_per_line  = 32'd640;
      lines_per_frame = 16'd2;
      vsync           = 1'b0;
      fifo_level      = 8'd0;
      bus.rd_ack      = 1'b0;
      bus.rd_done     = 1'b0;

      step();
      chk("rst_rd_req", {31'd0, bus.rd_req}, 32'd0);
      chk("rst_rd_addr", bus.rd_addr, 32'd0);
      chk("rst_rd_len", {20'd0, bus.rd_len}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
      resetn = 1'b1;
      step();

      // T1: full two-line frame
      enable = 1'b1;
      step();
      pulse_vsync();
      chk("t1_busy", {31'd0, busy}, 32'd1);
      for (int i = 0; i < 6; i++) begin
         wait_req(t1[i].addr, t1[i].len, t1[i].ack_dly, 1'b0);
         finish_done(t1[i].done_dly, t1[i].last, !t1[i].last);
      end

      // T2: insufficient FIFO space holds off the request
      fifo_level = 8'd100;
      pulse_vsync();
      chk("t2_busy", {31'd0, busy}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("t2_no_req", {31'd0, bus.rd_req}, 32'd0);
      end
      fifo_level = 8'd64;
      step();
      chk("t2_req_next", {31'd0, bus.rd_req}, 32'd1);

      // T3: ack delayed 10 cycles
      wait_req(32'h1000_0000, 12'd256, 10, 1'b0);
      finish_done(1, 1'b0, 1'b1);
      for (int i = 1; i < 3; i++) begin
         wait_req(t1[i].addr, t1[i].len, 0, 1'b0);
         finish_done(1, 1'b0, 1'b1);
      end

      // T4: resync during XFER of line 1
      wait_req(32'h1000_1000, 12'd256, 0, 1'b0);
      frame_base_addr = 32'h2000_0000;
      pulse_vsync();
      for (int i = 0; i < 4; i++) begin
         chk("t4_no_req", {31'd0, bus.rd_req}, 32'd0);
         chk("t4_busy", {31'd0, busy}, 32'd1);
         step();
      end
      finish_done(0, 1'b0, 1'b1);

      // T5: enable dropped while requesting
      wait_req(32'h2000_0000, 12'd256, 3, 1'b1);
      chk("t5_busy_xfer", {31'd0, busy}, 32'd1);
      finish_done(2, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t5_idle_req", {31'd0, bus.rd_req}, 32'd0);
         chk("t5_idle_fd", {31'd0, frame_done}, 32'd0);
      end

      // Zero bytes per line: vsync ignored
      enable         = 1'b1;
      fifo_level     = 8'd0;
      bytes_per_line = 32'd0;
      step(2);
      pulse_vsync();
      for (int i = 0; i < 5; i++) begin
         chk("bpl0_busy", {31'd0, busy}, 32'd0);
         chk("bpl0_req", {31'd0, bus.rd_req}, 32'd0);
         step();
      end

      // Tiny lines with address wrap across 2^32
      frame_base_addr = 32'hFFFF_FF00;
      line_stride     = 32'h0000_0200;
      bytes_per_line  = 32'd4;
      lines_per_frame = 16'd2;
      pulse_vsync();
      for (int i = 0; i < 2; i++) begin
         wait_req(t_wrap[i].addr, t_wrap[i].len, t_wrap[i].ack_dly, 1'b0);
         finish_done(t_wrap[i].done_dly, t_wrap[i].last, !t_wrap[i].last);
      end

      // T6: reset mid-XFER, then restart
      frame_base_addr = 32'h3000_0000;
      line_stride     = 32'd4096;
      bytes_per_line  = 32'd640;
      pulse_vsync();
      wait_req(32'h3000_0000, 12'd256, 1, 1'b0);
      step(2);
      resetn = 1'b0;
      #1;
      chk("t6_rd_req", {31'd0, bus.rd_req}, 32'd0);
      chk("t6_rd_addr", bus.rd_addr, 32'd0);
      chk("t6_rd_len", {20'd0, bus.rd_len}, 32'd0);
      chk("t6_busy", {31'd0, busy}, 32'd0);
      chk("t6_frame_done", {31'd0, frame_done}, 32'd0);
      step();
      resetn = 1'b1;
      step(2);
      pulse_vsync();
      wait_req(32'h3000_0000, 12'd256, 0, 1'b0);
      finish_done(1, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
